cu_round_seq: RTL

Parametrised round sequencer for the AES cipher unit. It drives the datapath mux selects, state-register enable/clear and the round-key index R for 128/192/256-bit keys in both directions. Unlike the first-generation controller it adds:
- valid/ready handshakes on block input and result output
- a channel tag carried with each block
- a synchronous abort
- a saturating processed-block counter

It sits between the key-schedule unit (KF, KL) and the cipher datapath.

---
 rtl/cu_pkg.sv | 65 ++++++
 rtl/cu_round_cnt.sv | 58 +++++
 rtl/cu_round_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared types and constants for the AES round sequencer: FSM states,
// key-length encodings, round counts and the datapath mux-select bundle.
package cu_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    E0,
    EX,
    EN,
    D0,
    DX,
    DN,
    DONE
  } state_t;

  localparam logic [1:0] KL_128 = 2'b00;
  localparam logic [1:0] KL_192 = 2'b01;

  localparam int unsigned NR128_DEF = 10;
  localparam int unsigned NR192_DEF = 12;
  localparam int unsigned NR256_DEF = 14;

  typedef struct packed {
    logic       mux0;
    logic       mux1;
    logic [1:0] mux2;
    logic       mux3;
    logic       mux4;
    logic       mux5;
    logic       mux6;
  } mux_sel_t;

  localparam mux_sel_t MUX_DEF = '{mux0: 1'b0, mux1: 1'b1, mux2: 2'd1, mux3: 1'b1,
                                   mux4: 1'b0, mux5: 1'b1, mux6: 1'b0};
  localparam mux_sel_t MUX_E0  = '{mux0: 1'b0, mux1: 1'b0, mux2: 2'd0, mux3: 1'b0,
                                   mux4: 1'b1, mux5: 1'b1, mux6: 1'b0};
  localparam mux_sel_t MUX_EX  = '{mux0: 1'b0, mux1: 1'b1, mux2: 2'd1, mux3: 1'b1,
                                   mux4: 1'b0, mux5: 1'b1, mux6: 1'b0};
  localparam mux_sel_t MUX_EN  = '{mux0: 1'b0, mux1: 1'b1, mux2: 2'd1, mux3: 1'b1,
                                   mux4: 1'b0, mux5: 1'b1, mux6: 1'b1};
  localparam mux_sel_t MUX_D0  = '{mux0: 1'b0, mux1: 1'b0, mux2: 2'd0, mux3: 1'b0,
                                   mux4: 1'b1, mux5: 1'b0, mux6: 1'b0};
  localparam mux_sel_t MUX_DX  = '{mux0: 1'b0, mux1: 1'b0, mux2: 2'd2, mux3: 1'b0,
                                   mux4: 1'b1, mux5: 1'b0, mux6: 1'b0};
  localparam mux_sel_t MUX_DN  = '{mux0: 1'b0, mux1: 1'b0, mux2: 2'd2, mux3: 1'b0,
                                   mux4: 1'b1, mux5: 1'b1, mux6: 1'b0};

  function automatic mux_sel_t mux_for(input state_t s);
    case (s)
      E0:      return MUX_E0;
      EX:      return MUX_EX;
      EN:      return MUX_EN;
      D0:      return MUX_D0;
      DX:      return MUX_DX;
      DN:      return MUX_DN;
      default: return MUX_DEF;
    endcase
  endfunction

  function automatic logic is_round(input state_t s);
    return (s inside {E0, EX, EN, D0, DX, DN});
  endfunction

endpackage

// File: rtl/cu_round_cnt.sv
// Round counter with Nr decode, last-round flag and round-key index mapping
// (ascending for encryption, descending Nr..0 for decryption).
module cu_round_cnt
  import cu_pkg::*;
#(
  parameter int unsigned RW    = 4,
  parameter int unsigned NR128 = NR128_DEF,
  parameter int unsigned NR192 = NR192_DEF,
  parameter int unsigned NR256 = NR256_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic          active_i,
  input  logic          enc_i,
  input  logic [1:0]    kl_i,
  output logic          last_o,
  output logic [RW-1:0] r_idx_o
);

  localparam logic [RW-1:0] NR128_W = RW'(NR128);
  localparam logic [RW-1:0] NR192_W = RW'(NR192);
  localparam logic [RW-1:0] NR256_W = RW'(NR256);

  logic [RW-1:0] r_q, r_d;
  logic [RW-1:0] nr;

  always_comb begin
    case (kl_i)
      KL_128:  nr = NR128_W;
      KL_192:  nr = NR192_W;
      default: nr = NR256_W;
    endcase
  end

  // Saturate at Nr so the index can never run past the final round key.
  always_comb begin
    r_d = r_q;
    if (clr_i) begin
      r_d = '0;
    end else if (inc_i && (r_q != nr)) begin
      r_d = r_q + RW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  assign last_o  = (r_q == (nr - RW'(1)));
  assign r_idx_o = !active_i ? '0 : (enc_i ? r_q : (nr - r_q));

endmodule

// File: rtl/cu_round_seq.sv
// AES round sequencer: block handshake, per-round datapath selects, state
// register control, round-key index and a saturating completed-block count.
module cu_round_seq
  import cu_pkg::*;
#(
  parameter int unsigned RW    = 4,
  parameter int unsigned NR128 = NR128_DEF,
  parameter int unsigned NR192 = NR192_DEF,
  parameter int unsigned NR256 = NR256_DEF,
  parameter int unsigned TAGW  = 2,
  parameter int unsigned CNTW  = 16
) (
  input  logic            CLK,
  input  logic            CLR_N,
  input  logic            KF,
  input  logic [1:0]      KL,
  input  logic            enc_dec,
  input  logic            in_valid,
  input  logic [TAGW-1:0] in_tag,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [TAGW-1:0] out_tag,
  input  logic            abort,
  output logic            busy,
  output logic            mux0,
  output logic            mux1,
  output logic [1:0]      mux2,
  output logic            mux3,
  output logic            mux4,
  output logic            mux5,
  output logic            mux6,
  output logic            SE,
  output logic            SCLR,
  output logic [RW-1:0]   R,
  output logic [CNTW-1:0] blk_cnt
);

  state_t          state_q, state_d;
  logic [1:0]      kl_q;
  logic            enc_q;
  logic [TAGW-1:0] tag_q;
  mux_sel_t        mux_q;
  logic            se_q, sclr_q, valid_q, busy_q;
  logic [CNTW-1:0] cnt_q;
  logic            accept, hs, last, inc;

  assign accept = (state_q == LOAD) && KF && in_valid && !abort;
  assign hs     = (state_q == DONE) && out_ready && !abort;
  assign inc    = (state_q inside {E0, EX, D0, DX});

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (KF) state_d = LOAD;
      LOAD: begin
        if (!KF)         state_d = IDLE;
        else if (accept) state_d = enc_dec ? E0 : D0;
      end
      E0:   state_d = EX;
      EX:   state_d = last ? EN : EX;
      EN:   state_d = DONE;
      D0:   state_d = DX;
      DX:   state_d = last ? DN : DX;
      DN:   state_d = DONE;
      DONE: if (hs) state_d = KF ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= IDLE;
      kl_q    <= '0;
      enc_q   <= 1'b0;
      tag_q   <= '0;
      mux_q   <= MUX_DEF;
      se_q    <= 1'b0;
      sclr_q  <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mux_q   <= mux_for(state_d);
      se_q    <= is_round(state_d);
      busy_q  <= is_round(state_d);
      sclr_q  <= (state_d == IDLE);
      valid_q <= (state_d == DONE);
      if (accept) begin
        kl_q  <= KL;
        enc_q <= enc_dec;
        tag_q <= in_tag;
      end
      if (hs && (cnt_q != '1)) cnt_q <= cnt_q + CNTW'(1);
    end
  end

  cu_round_cnt #(
    .RW    (RW),
    .NR128 (NR128),
    .NR192 (NR192),
    .NR256 (NR256)
  ) u_round_cnt (
    .clk_i    (CLK),
    .rst_ni   (CLR_N),
    .clr_i    (accept),
    .inc_i    (inc),
    .active_i (busy_q),
    .enc_i    (enc_q),
    .kl_i     (kl_q),
    .last_o   (last),
    .r_idx_o  (R)
  );

  // The accept cycle loads the input block, so SE/mux0 follow the handshake.
  assign in_ready  = (state_q == LOAD) && KF;
  assign SE        = se_q | accept;
  assign mux0      = mux_q.mux0 | accept;
  assign mux1      = mux_q.mux1;
  assign mux2      = mux_q.mux2;
  assign mux3      = mux_q.mux3;
  assign mux4      = mux_q.mux4;
  assign mux5      = mux_q.mux5;
  assign mux6      = mux_q.mux6;
  assign SCLR      = sclr_q;
  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_tag   = tag_q;
  assign blk_cnt   = cnt_q;

endmodule
